cache_rdport_arbiter: RTL and testbench
=======================================

# cache_rdport_arbiter

Shares the single cache read port (rdreq/rdresp) between NREQ requesters, e.g. the cache-to-net write-back path and the compute feeder, inside the LU tile. Grants are burst-locked, so once a requester wins it owns the port until it issues a beat flagged last. Arbitration between bursts is round-robin. The block tracks outstanding reads in an owner-tag FIFO, which lets it route in-order cache responses back to the requester that issued them.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- AWIDTH, CACHE_AWIDTH, cache address width
- DWIDTH, CACHE_DWIDTH, cache data width (LANES*32)
- TAG_DEPTH, 8, max outstanding reads (power of 2)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  reset, synchronous, active-low
- i_req_addr  in  NREQ×AWIDTH  per-requester read address
- i_req_which  in  NREQ×4  per-requester buffer/page select
- i_req_last  in  NREQ  beat is the last of the burst
- i_req_valid  in  NREQ  request valid
- o_req_ready  out  NREQ  request accepted when valid&ready
- o_cache_rdreq_addr  out  AWIDTH  to cache
- o_cache_rdreq_which  out  4  to cache
- o_cache_rdreq_valid  out  1  to cache
- i_cache_rdreq_ready  in  1  from cache
- i_cache_rdresp_data  in  DWIDTH  from cache, in issue order
- i_cache_rdresp_valid  in  1  from cache
- o_cache_rdresp_ready  out  1  to cache
- o_resp_data  out  DWIDTH  broadcast to all requesters
- o_resp_valid  out  NREQ  one-hot, valid for the owning requester
- i_resp_ready  in  NREQ  per-requester response ready
- o_owner  out  clog2(NREQ)  current/last grant owner
- o_busy  out  1  state==LOCKED or tag FIFO non-empty
- o_err  out  1  sticky; response arrived with no outstanding tag

## Operation
- The FSM has two states, IDLE and LOCKED.
- IDLE: no request is forwarded, and all o_req_ready and o_cache_rdreq_valid are 0.
  - If any i_req_valid is set, the winner is the first valid index at or after rr_ptr, searching upward modulo NREQ.
  - On that cycle, owner<=winner and the FSM goes to LOCKED.
- LOCKED:
  - o_cache_rdreq_addr/which = i_req_addr/which[owner].
  - o_cache_rdreq_valid = i_req_valid[owner] & !tag_full.
  - o_req_ready[owner] = i_cache_rdreq_ready & !tag_full. Other o_req_ready bits are 0.
- Issue occurs when o_cache_rdreq_valid & i_cache_rdreq_ready. On issue, push owner into the tag FIFO.
- Issue with i_req_last[owner]=1: go to IDLE and set rr_ptr<=(owner+1) mod NREQ.
- Response routing, with head = tag FIFO head:
  - o_resp_valid[head] = i_cache_rdresp_valid & !tag_empty. Other bits are 0.
  - o_resp_data = i_cache_rdresp_data.
  - o_cache_rdresp_ready = i_resp_ready[head] & !tag_empty.
  - Pop on i_cache_rdresp_valid & o_cache_rdresp_ready.
- Tag FIFO counter width is clog2(TAG_DEPTH+1). Read and write pointers wrap modulo TAG_DEPTH.
- Full: push is blocked even if a pop occurs in the same cycle, so full is never relieved combinationally.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
- Response with tag_empty: not accepted, o_err<=1. o_err stays set until reset.
- Non-owner requesters that drop valid are legal. An owner that drops valid mid-burst keeps the lock.

## Timing
- Reset (reset_n=0 at a clk edge) sets:
  - state=IDLE, rr_ptr=0, owner=0
  - tag FIFO empty
  - o_err=0, o_busy=0
  - all o_req_ready, o_cache_rdreq_valid, o_resp_valid and o_cache_rdresp_ready = 0
- Reset mid-burst drops all outstanding tags. The cache must be reset in the same cycle.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N can issue at edge N+1.
- Each burst costs exactly 1 bubble cycle (the IDLE cycle) between bursts.
- The request path (i_req_* to o_cache_rdreq_*) and the response path (i_cache_rdresp_* to o_resp_*) are combinational, with 0 added latency.
- Within a burst, throughput is 1 beat/cycle while the cache is ready and tags are available.

## Test plan
- Single burst: req0 issues 4 beats (addr 0,8,16,24), last on 24, with the cache responding 2 cycles later.
  - Expect rdreq addr 0,8,16,24 back-to-back starting 1 cycle after valid.
  - Expect o_resp_valid=01 for 4 beats, then o_busy=0.
- Contention: req0 and req1 are both valid with 2-beat bursts, starting from rr_ptr=0.
  - Expect grant order 0,1,0,1, one IDLE cycle between bursts, and o_owner toggling.
- Tag full: TAG_DEPTH=8 with the cache never responding.
  - After 8 issues, o_req_ready[owner]=0 and o_cache_rdreq_valid=0.
  - A single response pops one tag, and exactly one more issue follows.
- Response backpressure: owner tag at head, i_resp_ready[head]=0 while the cache holds valid.
  - Expect o_cache_rdresp_ready=0 and no pop.
  - Data is delivered in the cycle ready rises.
- Spurious response: i_cache_rdresp_valid=1 with no outstanding issue.
  - Expect o_cache_rdresp_ready=0, o_err=1 the next cycle, and o_err still 1 100 cycles later.
- Reset mid-burst: reset_n=0 for 1 cycle after beat 2 of 4.
  - Expect IDLE, rr_ptr=0, empty FIFO and all outputs 0.
  - Re-arbitration then starts from requester 0.

Source files
------------

// File: rtl/cache_rdport_arbiter.sv
// Burst-locked round-robin arbiter sharing one cache read port between NREQ requesters.
// An owner-tag FIFO steers the in-order cache responses back to the issuing requester.
module cache_rdport_arbiter #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned AWIDTH    = 16,
    parameter int unsigned DWIDTH    = 128,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NREQ-1:0][AWIDTH-1:0]     i_req_addr,
    input  logic [NREQ-1:0][3:0]            i_req_which,
    input  logic [NREQ-1:0]                 i_req_last,
    input  logic [NREQ-1:0]                 i_req_valid,
    output logic [NREQ-1:0]                 o_req_ready,
    output logic [AWIDTH-1:0]               o_cache_rdreq_addr,
    output logic [3:0]                      o_cache_rdreq_which,
    output logic                            o_cache_rdreq_valid,
    input  logic                            i_cache_rdreq_ready,
    input  logic [DWIDTH-1:0]               i_cache_rdresp_data,
    input  logic                            i_cache_rdresp_valid,
    output logic                            o_cache_rdresp_ready,
    output logic [DWIDTH-1:0]               o_resp_data,
    output logic [NREQ-1:0]                 o_resp_valid,
    input  logic [NREQ-1:0]                 i_resp_ready,
    output logic [$clog2(NREQ)-1:0]         o_owner,
    output logic                            o_busy,
    output logic                            o_err
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned PW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = $clog2(TAG_DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic [OW-1:0]   tag_mem_q [TAG_DEPTH];

    logic            tag_full, tag_empty, push, pop, found;
    logic [OW-1:0]   winner, head;
    int unsigned     cand;

    assign tag_full  = (count_q == CW'(TAG_DEPTH));
    assign tag_empty = (count_q == '0);
    assign head      = tag_mem_q[rptr_q];

    // First valid requester at or after rr_ptr, searching upward modulo NREQ.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NREQ;
            if (!found && i_req_valid[cand]) begin
                found  = 1'b1;
                winner = OW'(cand);
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        rr_ptr_d            = rr_ptr_q;
        o_req_ready         = '0;
        o_cache_rdreq_valid = 1'b0;
        o_cache_rdreq_addr  = i_req_addr[owner_q];
        o_cache_rdreq_which = i_req_which[owner_q];
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d = winner;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                o_cache_rdreq_valid  = i_req_valid[owner_q] & ~tag_full;
                o_req_ready[owner_q] = i_cache_rdreq_ready & ~tag_full;
                if (i_req_valid[owner_q] && !tag_full && i_cache_rdreq_ready
                    && i_req_last[owner_q]) begin
                    state_d  = StIdle;
                    rr_ptr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign push = o_cache_rdreq_valid & i_cache_rdreq_ready;

    always_comb begin
        o_resp_valid         = '0;
        o_resp_valid[head]   = i_cache_rdresp_valid & ~tag_empty;
        o_cache_rdresp_ready = i_resp_ready[head] & ~tag_empty;
    end

    assign pop         = i_cache_rdresp_valid & o_cache_rdresp_ready;
    assign o_resp_data = i_cache_rdresp_data;

    // Push is already gated by full, so a same-cycle pop never frees a slot early.
    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        err_d = err_q | (i_cache_rdresp_valid & tag_empty);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wptr_q] <= owner_q;
        end
    end

    assign o_owner = owner_q;
    assign o_busy  = (state_q == StLocked) | ~tag_empty;
    assign o_err   = err_q;

endmodule

// File: tb/tb_cache_rdport_arbiter.sv
// Bench for cache_rdport_arbiter: cache model with fixed response latency, a response
// scoreboard keyed by requester, an arbitration vector table and multi-cycle sequences.
module tb_cache_rdport_arbiter;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [1:0][15:0]   req_addr;
    logic [1:0][3:0]    req_which;
    logic [1:0]         req_last, req_valid, req_ready;
    logic [15:0]        rq_addr;
    logic [3:0]         rq_which;
    logic               rq_valid, cache_ready;
    logic               model_valid, man_mode, man_valid, resp_en;
    logic [31:0]        model_data, man_data, resp_data;
    logic               rdresp_valid, rdresp_ready;
    logic [31:0]        rdresp_data;
    logic [1:0]         resp_valid, resp_ready;
    logic [0:0]         owner;
    logic               busy, err;

    assign rdresp_valid = man_mode ? man_valid : model_valid;
    assign rdresp_data  = man_mode ? man_data : model_data;

    always #5 clk = ~clk;

    cache_rdport_arbiter #(
        .NREQ(2), .AWIDTH(16), .DWIDTH(32), .TAG_DEPTH(8)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .i_req_addr           (req_addr),
        .i_req_which          (req_which),
        .i_req_last           (req_last),
        .i_req_valid          (req_valid),
        .o_req_ready          (req_ready),
        .o_cache_rdreq_addr   (rq_addr),
        .o_cache_rdreq_which  (rq_which),
        .o_cache_rdreq_valid  (rq_valid),
        .i_cache_rdreq_ready  (cache_ready),
        .i_cache_rdresp_data  (rdresp_data),
        .i_cache_rdresp_valid (rdresp_valid),
        .o_cache_rdresp_ready (rdresp_ready),
        .o_resp_data          (resp_data),
        .o_resp_valid         (resp_valid),
        .i_resp_ready         (resp_ready),
        .o_owner              (owner),
        .o_busy               (busy),
        .o_err                (err)
    );

    typedef struct { int r; logic [31:0] d; } exp_t;
    typedef struct { int t; logic [15:0] a; } pend_t;
    typedef struct { logic [1:0] valid; int owner; } arb_vec_t;

    exp_t     exp_q[$];
    pend_t    pend_q[$];
    int       tests = 0;
    int       fails = 0;
    int       cyc = 0;

    function automatic logic [31:0] dfun(logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe handshakes just before the edge, then drive the cache model.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        if (reset_n) begin
            for (int r = 0; r < 2; r++)
                if (req_valid[r] && req_ready[r]) exp_q.push_back('{r, dfun(req_addr[r])});
            if (rq_valid && cache_ready) pend_q.push_back('{cyc, rq_addr});
            for (int r = 0; r < 2; r++) begin
                if (resp_valid[r] && resp_ready[r]) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_resp", 64'(r), 64'hdead);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_owner", 64'(r), 64'(e.r));
                        check("sb_data", 64'(resp_data), 64'(e.d));
                    end
                end
            end
            if (rdresp_valid && rdresp_ready && pend_q.size() > 0) pend_q.delete(0);
        end
        #1;
        model_valid = 1'b0;
        model_data  = '0;
        if (resp_en && pend_q.size() > 0 && cyc - pend_q[0].t >= 2) begin
            model_valid = 1'b1;
            model_data  = dfun(pend_q[0].a);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        man_mode = 1'b0;
        man_valid = 1'b0;
        resp_en = 1'b1;
        resp_ready = 2'b11;
        tick();
        tick();
        exp_q.delete();
        pend_q.delete();
        model_valid = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(string name);
        for (int i = 0; i < 60 && (exp_q.size() > 0 || busy); i++) tick();
        #1;
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    arb_vec_t arb_tbl[8];
    int       pat[12];
    int       rem[2];
    int       act, issues;
    logic [15:0] a;
    logic     acc;

    initial begin
        arb_tbl[0] = '{2'b11, 0}; arb_tbl[1] = '{2'b11, 1};
        arb_tbl[2] = '{2'b10, 1}; arb_tbl[3] = '{2'b10, 1};
        arb_tbl[4] = '{2'b01, 0}; arb_tbl[5] = '{2'b01, 0};
        arb_tbl[6] = '{2'b11, 1}; arb_tbl[7] = '{2'b11, 0};
        pat = '{-1, 0, 0, -1, 1, 1, -1, 0, 0, -1, 1, 1};
        req_addr = '0;
        req_which = {4'd2, 4'd1};
        cache_ready = 1'b1;
        man_data = '0;
        model_valid = 1'b0;
        model_data = '0;

        // Reset state
        do_reset();
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_err", 64'(err), 0);
        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_rdreq_valid", 64'(rq_valid), 0);
        check("rst_resp_valid", 64'(resp_valid), 0);
        check("rst_rdresp_ready", 64'(rdresp_ready), 0);
        check("rst_owner", 64'(owner), 0);

        // Single 4-beat burst from requester 0
        req_valid = 2'b01;
        req_addr[0] = 16'd0;
        #1;
        check("burst_idle_rdreq_valid", 64'(rq_valid), 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            req_addr[0] = 16'(8 * k);
            req_last[0] = (k == 3);
            #1;
            check("burst_rdreq_valid", 64'(rq_valid), 1);
            check("burst_rdreq_addr", 64'(rq_addr), 64'(8 * k));
            check("burst_rdreq_which", 64'(rq_which), 1);
            check("burst_req_ready", 64'(req_ready), 2'b01);
            tick();
        end
        req_valid = '0;
        req_last = '0;
        #1;
        check("burst_back_idle", 64'(rq_valid), 0);
        wait_drain("burst");

        // Contention: two 2-beat bursts each, round-robin from rr_ptr=0
        do_reset();
        rem = '{4, 4};
        for (int c = 0; c < 12; c++) begin
            for (int r = 0; r < 2; r++) begin
                req_valid[r] = rem[r] > 0;
                req_addr[r] = 16'(16'h100 * (r + 1) + (4 - rem[r]) * 8);
                req_last[r] = rem[r][0];
            end
            #1;
            act = -1;
            for (int r = 0; r < 2; r++) if (req_valid[r] && req_ready[r]) act = r;
            check("rr_pattern", 64'(act), 64'(pat[c]));
            if (pat[c] >= 0) check("rr_owner", 64'(owner), 64'(pat[c]));
            tick();
            if (act >= 0) rem[act]--;
        end
        req_valid = '0;
        wait_drain("rr");

        // Arbitration vector table, single-beat bursts
        do_reset();
        req_last = 2'b11;
        for (int i = 0; i < 8; i++) begin
            req_valid = arb_tbl[i].valid;
            req_addr[0] = 16'(16'h200 + i * 4);
            req_addr[1] = 16'(16'h280 + i * 4);
            #1;
            check("arb_idle_ready", 64'(req_ready), 0);
            tick();
            #1;
            check("arb_owner", 64'(owner), 64'(arb_tbl[i].owner));
            check("arb_ready", 64'(req_ready), 64'(1 << arb_tbl[i].owner));
            tick();
            req_valid = '0;
        end
        wait_drain("arb");

        // Tag FIFO full, cache silent
        do_reset();
        resp_en = 1'b0;
        req_valid = 2'b01;
        req_last = '0;
        a = 16'd0;
        tick();
        issues = 0;
        for (int c = 0; c < 12; c++) begin
            req_addr[0] = a;
            #1;
            if (req_ready[0]) begin issues++; a += 16'd4; end
            tick();
        end
        req_addr[0] = a;
        #1;
        check("full_issue_count", 64'(issues), 8);
        check("full_req_ready", 64'(req_ready), 0);
        check("full_rdreq_valid", 64'(rq_valid), 0);
        man_mode = 1'b1;
        man_valid = 1'b1;
        man_data = dfun(16'd0);
        #1;
        check("full_rdresp_ready", 64'(rdresp_ready), 1);
        check("full_no_early_relief", 64'(rq_valid), 0);
        issues = 0;
        for (int c = 0; c < 7; c++) begin
            req_addr[0] = a;
            #1;
            if (req_ready[0]) begin issues++; a += 16'd4; end
            tick();
            man_valid = 1'b0;
        end
        check("full_one_more_issue", 64'(issues), 1);
        man_mode = 1'b0;
        resp_en = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 40 && !acc; c++) begin
            req_addr[0] = a;
            req_last[0] = 1'b1;
            #1;
            acc = req_ready[0];
            tick();
        end
        check("full_last_issued", 64'(acc), 1);
        req_valid = '0;
        req_last = '0;
        wait_drain("full");

        // Response backpressure
        do_reset();
        resp_ready = 2'b00;
        req_valid = 2'b01;
        req_last = 2'b01;
        req_addr[0] = 16'h40;
        tick();
        tick();
        req_valid = '0;
        for (int c = 0; c < 10 && !rdresp_valid; c++) tick();
        #1;
        check("bp_cache_valid", 64'(rdresp_valid), 1);
        check("bp_resp_valid", 64'(resp_valid), 2'b01);
        check("bp_rdresp_ready", 64'(rdresp_ready), 0);
        tick();
        tick();
        tick();
        #1;
        check("bp_no_pop", 64'(exp_q.size()), 1);
        check("bp_busy_held", 64'(busy), 1);
        resp_ready = 2'b11;
        #1;
        check("bp_release_ready", 64'(rdresp_ready), 1);
        check("bp_release_data", 64'(resp_data), 64'(dfun(16'h40)));
        tick();
        #1;
        check("bp_popped_busy", 64'(busy), 0);
        check("bp_popped_sb", 64'(exp_q.size()), 0);

        // Spurious response
        do_reset();
        man_mode = 1'b1;
        man_valid = 1'b1;
        man_data = 32'h1234_5678;
        #1;
        check("spur_rdresp_ready", 64'(rdresp_ready), 0);
        check("spur_resp_valid", 64'(resp_valid), 0);
        check("spur_err_before", 64'(err), 0);
        tick();
        man_valid = 1'b0;
        #1;
        check("spur_err_set", 64'(err), 1);
        for (int c = 0; c < 100; c++) tick();
        #1;
        check("spur_err_sticky", 64'(err), 1);

        // Reset mid-burst: move rr_ptr to 1, lock requester 1, reset after beat 2 of 4
        do_reset();
        req_valid = 2'b01;
        req_last = 2'b01;
        req_addr[0] = 16'h10;
        tick();
        tick();
        req_valid = '0;
        wait_drain("mid_pre");
        resp_en = 1'b0;
        req_valid = 2'b10;
        req_last = '0;
        req_addr[1] = 16'h300;
        tick();
        #1;
        check("mid_owner_before", 64'(owner), 1);
        for (int k = 0; k < 2; k++) begin
            req_addr[1] = 16'(16'h300 + 8 * k);
            tick();
        end
        req_valid = 2'b11;
        reset_n = 1'b0;
        tick();
        exp_q.delete();
        pend_q.delete();
        model_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        check("mid_busy", 64'(busy), 0);
        check("mid_rdreq_valid", 64'(rq_valid), 0);
        check("mid_req_ready", 64'(req_ready), 0);
        check("mid_owner", 64'(owner), 0);
        check("mid_resp_valid", 64'(resp_valid), 0);
        check("mid_err", 64'(err), 0);
        req_last = 2'b11;
        tick();
        #1;
        check("mid_rearb_owner", 64'(owner), 0);
        check("mid_rearb_ready", 64'(req_ready), 2'b01);
        tick();
        req_valid = '0;
        resp_en = 1'b1;
        wait_drain("mid_post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
